// File: rtl/iq_modu_pkg.sv
// Shared mode encoding and width helpers for the I/Q up-converter family.
package iq_modu_pkg;

    typedef enum logic [1:0] {
        MODE_IQ   = 2'b00,
        MODE_I    = 2'b01,
        MODE_BYP  = 2'b10,
        MODE_MUTE = 2'b11
    } mode_e;

    // Full-precision width of a signed a-bit by b-bit product.
    function automatic int unsigned prod_w(input int unsigned a, input int unsigned b);
        return a + b;
    endfunction

endpackage

// File: rtl/iq_upconv_modu_if.sv
// Sample-stream bundle between the baseband source and the up-converter.
interface iq_upconv_modu_if #(
    parameter int unsigned DIN_W  = 16,
    parameter int unsigned LO_W   = 16,
    parameter int unsigned DOUT_W = 16
);

    logic                     in_valid;
    logic [1:0]               mode;
    logic signed [DIN_W-1:0]  i_in;
    logic signed [DIN_W-1:0]  q_in;
    logic signed [LO_W-1:0]   cos_in;
    logic signed [LO_W-1:0]   sin_in;
    logic                     sat_clr;
    logic signed [DOUT_W-1:0] y_out;
    logic                     out_valid;
    logic                     sat_flag;

    modport master (
        output in_valid, mode, i_in, q_in, cos_in, sin_in, sat_clr,
        input  y_out, out_valid, sat_flag
    );

    modport slave (
        input  in_valid, mode, i_in, q_in, cos_in, sin_in, sat_clr,
        output y_out, out_valid, sat_flag
    );

endinterface

// File: rtl/round_sat.sv
// Round-half-up arithmetic right shift followed by saturation to OUT_W.
module round_sat #(
    parameter int unsigned IN_W  = 33,
    parameter int unsigned OUT_W = 16,
    parameter int unsigned SHIFT = 15
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout,
    output logic                    ovf
);

    // One guard bit so adding the rounding half can never wrap.
    localparam int unsigned RW = IN_W + 1;

    localparam logic signed [OUT_W-1:0] MAX_V = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] MIN_V = {1'b1, {(OUT_W-1){1'b0}}};

    logic signed [RW-1:0] ext_c;
    logic signed [RW-1:0] rnd_c;

    assign ext_c = RW'(din);

    // Add half an LSB of the result, then floor-shift: ties go toward +inf.
    generate
        if (SHIFT > 0) begin : g_rnd
            localparam logic signed [RW-1:0] HALF = RW'(1) << (SHIFT - 1);
            assign rnd_c = (ext_c + HALF) >>> SHIFT;
        end else begin : g_no_rnd
            assign rnd_c = ext_c;
        end
    endgenerate

    // Overflow when the bits above the output sign bit disagree with it.
    generate
        if (RW > OUT_W) begin : g_sat
            logic [RW-OUT_W:0] top_c;
            assign top_c = rnd_c[RW-1:OUT_W-1];
            assign ovf   = ~((&top_c) | ~(|top_c));
            assign dout  = ovf ? (rnd_c[RW-1] ? MIN_V : MAX_V) : rnd_c[OUT_W-1:0];
        end else begin : g_no_sat
            assign ovf  = 1'b0;
            assign dout = OUT_W'(rnd_c);
        end
    endgenerate

endmodule

// File: rtl/iq_upconv_modu.sv
// Four-stage pipelined I/Q up-converter: y = I*cos - Q*sin, rounded and saturated.
module iq_upconv_modu
    import iq_modu_pkg::*;
#(
    parameter int unsigned DIN_W  = 16,
    parameter int unsigned LO_W   = 16,
    parameter int unsigned DOUT_W = 16,
    parameter int unsigned SHIFT  = 15
) (
    input  logic           clk_30p72MHz,
    input  logic           reset,
    iq_upconv_modu_if.slave bus
);

    localparam int unsigned P  = prod_w(DIN_W, LO_W);
    localparam int unsigned SW = P + 1;

    // Stage 1 registers
    logic                    v1;
    mode_e                   mode1;
    logic signed [DIN_W-1:0] i1;
    logic signed [DIN_W-1:0] q1;
    logic signed [LO_W-1:0]  cos1;
    logic signed [LO_W-1:0]  sin1;

    // Stage 2 registers
    logic                    v2;
    mode_e                   mode2;
    logic signed [DIN_W-1:0] i2;
    logic signed [P-1:0]     p0;
    logic signed [P-1:0]     p1;

    // Stage 3 registers
    logic                    v3;
    logic signed [SW-1:0]    s3;
    logic signed [SW-1:0]    s_nxt;

    // Stage 4 / output registers
    logic signed [DOUT_W-1:0] y_q;
    logic                     v_q;
    logic                     sat_q;
    logic signed [DOUT_W-1:0] r_c;
    logic                     ovf_c;

    // S1: capture the input sample with its mode and valid tag.
    always_ff @(posedge clk_30p72MHz) begin
        if (reset) begin
            v1    <= 1'b0;
            mode1 <= MODE_IQ;
            i1    <= '0;
            q1    <= '0;
            cos1  <= '0;
            sin1  <= '0;
        end else begin
            v1    <= bus.in_valid;
            mode1 <= mode_e'(bus.mode);
            i1    <= bus.i_in;
            q1    <= bus.q_in;
            cos1  <= bus.cos_in;
            sin1  <= bus.sin_in;
        end
    end

    // S2: full-precision signed products; I is carried along for bypass.
    always_ff @(posedge clk_30p72MHz) begin
        if (reset) begin
            v2    <= 1'b0;
            mode2 <= MODE_IQ;
            i2    <= '0;
            p0    <= '0;
            p1    <= '0;
        end else begin
            v2    <= v1;
            mode2 <= mode1;
            i2    <= i1;
            p0    <= P'(i1) * P'(cos1);
            p1    <= P'(q1) * P'(sin1);
        end
    end

    // S3 select: one extra bit so the full-scale difference cannot wrap.
    always_comb begin
        s_nxt = '0;
        case (mode2)
            MODE_IQ:  s_nxt = SW'(p0) - SW'(p1);
            MODE_I:   s_nxt = SW'(p0);
            MODE_BYP: s_nxt = SW'(i2) <<< SHIFT;
            default:  s_nxt = '0;
        endcase
    end

    // S3: register the mode-selected sum.
    always_ff @(posedge clk_30p72MHz) begin
        if (reset) begin
            v3 <= 1'b0;
            s3 <= '0;
        end else begin
            v3 <= v2;
            s3 <= s_nxt;
        end
    end

    round_sat #(
        .IN_W  (SW),
        .OUT_W (DOUT_W),
        .SHIFT (SHIFT)
    ) u_round_sat (
        .din  (s3),
        .dout (r_c),
        .ovf  (ovf_c)
    );

    // S4: output register holds on idle slots; a new saturation beats a clear.
    always_ff @(posedge clk_30p72MHz) begin
        if (reset) begin
            y_q   <= '0;
            v_q   <= 1'b0;
            sat_q <= 1'b0;
        end else begin
            v_q <= v3;
            if (v3) begin
                y_q <= r_c;
            end
            if (v3 && ovf_c) begin
                sat_q <= 1'b1;
            end else if (bus.sat_clr) begin
                sat_q <= 1'b0;
            end
        end
    end

    assign bus.y_out     = y_q;
    assign bus.out_valid = v_q;
    assign bus.sat_flag  = sat_q;

endmodule

// File: tb/tb_iq_upconv_modu.sv
// Directed and random checks of iq_upconv_modu against an integer reference.
module tb_iq_upconv_modu;

    localparam int unsigned DIN_W  = 16;
    localparam int unsigned LO_W   = 16;
    localparam int unsigned DOUT_W = 16;
    localparam int unsigned SHIFT  = 15;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    iq_upconv_modu_if #(.DIN_W(DIN_W), .LO_W(LO_W), .DOUT_W(DOUT_W)) bus ();

    iq_upconv_modu #(
        .DIN_W  (DIN_W),
        .LO_W   (LO_W),
        .DOUT_W (DOUT_W),
        .SHIFT  (SHIFT)
    ) dut (
        .clk_30p72MHz (clk),
        .reset        (reset),
        .bus          (bus)
    );

    int checks = 0;
    int errors = 0;

    // Current stimulus copy
    bit         cur_v;
    bit         cur_clr;
    logic [1:0] cur_m;
    int         cur_i, cur_q, cur_c, cur_s;

    // Reference pipeline: three internal stages plus output state
    bit mv [1:3];
    int my [1:3];
    bit ms [1:3];
    int ey;
    bit ev;
    bit esat;

    typedef struct {
        logic [1:0] m;
        int         i;
        int         q;
        int         c;
        int         s;
        int         y;
        bit         flag;
    } vec_t;

    vec_t tbl [11];

    // Integer reference: y = round_half_up(sum / 2^SHIFT), saturated to 16 bits.
    function automatic void calc(input logic [1:0] m, input int i, input int q,
                                 input int c, input int s, output int y, output bit sat);
        longint p0, p1, sv, r;
        p0 = longint'(i) * longint'(c);
        p1 = longint'(q) * longint'(s);
        case (m)
            2'b00:   sv = p0 - p1;
            2'b01:   sv = p0;
            2'b10:   sv = longint'(i) * (longint'(1) << SHIFT);
            default: sv = 0;
        endcase
        r   = (sv + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
        sat = 1'b0;
        if (r > 32767) begin
            r   = 32767;
            sat = 1'b1;
        end else if (r < -32768) begin
            r   = -32768;
            sat = 1'b1;
        end
        y = int'(r);
    endfunction

    task automatic chk(input string name, input logic signed [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit v, input logic [1:0] m, input int i, input int q,
                         input int c, input int s);
        cur_v = v; cur_m = m; cur_i = i; cur_q = q; cur_c = c; cur_s = s;
        bus.in_valid = v;
        bus.mode     = m;
        bus.i_in     = DIN_W'(i);
        bus.q_in     = DIN_W'(q);
        bus.cos_in   = LO_W'(c);
        bus.sin_in   = LO_W'(s);
    endtask

    task automatic set_clr(input bit x);
        cur_clr     = x;
        bus.sat_clr = x;
    endtask

    // One clock: advance the reference, then compare all outputs just after the edge.
    task automatic step();
        int yv;
        bit sv;
        calc(cur_m, cur_i, cur_q, cur_c, cur_s, yv, sv);
        @(posedge clk);
        if (reset) begin
            for (int k = 1; k <= 3; k++) begin
                mv[k] = 1'b0; my[k] = 0; ms[k] = 1'b0;
            end
            ey = 0; ev = 1'b0; esat = 1'b0;
        end else begin
            if (mv[3]) ey = my[3];
            ev = mv[3];
            if (mv[3] && ms[3]) esat = 1'b1;
            else if (cur_clr)   esat = 1'b0;
            for (int k = 3; k > 1; k--) begin
                mv[k] = mv[k-1]; my[k] = my[k-1]; ms[k] = ms[k-1];
            end
            mv[1] = cur_v; my[1] = yv; ms[1] = sv;
        end
        #1;
        chk("model_y", bus.y_out, ey);
        chk("model_valid", bus.out_valid, int'(ev));
        chk("model_flag", bus.sat_flag, int'(esat));
    endtask

    function automatic int rnd_val();
        int r;
        r = int'($urandom_range(0, 7));
        if (r == 0) return -32768;
        if (r == 1) return 32767;
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    initial begin
        tbl[0]  = '{2'b00,  16384,     0,  32767,      0,  16384, 1'b0};
        tbl[1]  = '{2'b01,  -1234,  1000,  32767,  32767,  -1234, 1'b0};
        tbl[2]  = '{2'b10,  -1234,  1000,  32767,  32767,  -1234, 1'b0};
        tbl[3]  = '{2'b11,  -1234,  1000,  32767,  32767,      0, 1'b0};
        tbl[4]  = '{2'b00,  -1234,  1000,  32767,  32767,  -2234, 1'b0};
        tbl[5]  = '{2'b01,      1,     0,  16384,      0,      1, 1'b0};
        tbl[6]  = '{2'b01,     -1,     0,  16384,      0,      0, 1'b0};
        tbl[7]  = '{2'b10, -32768,     0,      0,      0, -32768, 1'b0};
        tbl[8]  = '{2'b01, -32768,     0, -32768,      0,  32767, 1'b1};
        tbl[9]  = '{2'b00, -32768, 32767,  32767,  32767, -32768, 1'b1};
        tbl[10] = '{2'b00, -32768, 32767, -32768, -32768,  32767, 1'b1};

        for (int k = 1; k <= 3; k++) begin
            mv[k] = 1'b0; my[k] = 0; ms[k] = 1'b0;
        end
        ey = 0; ev = 1'b0; esat = 1'b0;
        set_clr(1'b0);
        drive(1'b0, 2'b00, 0, 0, 0, 0);

        // Reset held with busy inputs, then four idle cycles after release
        reset = 1'b1;
        for (int n = 0; n < 3; n++) begin
            drive(1'b1, 2'($urandom_range(0, 3)), rnd_val(), rnd_val(), rnd_val(), rnd_val());
            step();
            chk("rst_y", bus.y_out, 0);
            chk("rst_valid", bus.out_valid, 0);
            chk("rst_flag", bus.sat_flag, 0);
        end
        reset = 1'b0;
        drive(1'b0, 2'b00, 0, 0, 0, 0);
        for (int n = 0; n < 4; n++) begin
            step();
            chk("post_rst_valid", bus.out_valid, 0);
            chk("post_rst_y", bus.y_out, 0);
        end

        // Single nominal pulse: valid exactly on the fourth cycle, then hold
        drive(1'b1, 2'b00, 16384, 0, 32767, 0);
        step();
        drive(1'b0, 2'b00, 0, 0, 0, 0);
        step(); chk("nom_lat1", bus.out_valid, 0);
        step(); chk("nom_lat2", bus.out_valid, 0);
        step();
        chk("nom_valid", bus.out_valid, 1);
        chk("nom_y", bus.y_out, 16384);
        chk("nom_flag", bus.sat_flag, 0);
        step();
        chk("nom_drop", bus.out_valid, 0);
        chk("nom_hold", bus.y_out, 16384);

        // Saturation, stickiness and clear
        drive(1'b1, 2'b00, -32768, 32767, -32768, -32768);
        step();
        drive(1'b0, 2'b00, 0, 0, 0, 0);
        step(); step(); step();
        chk("sat_y", bus.y_out, 32767);
        chk("sat_flag_set", bus.sat_flag, 1);
        step(); step();
        chk("sat_flag_held", bus.sat_flag, 1);
        set_clr(1'b1); step(); set_clr(1'b0);
        chk("sat_flag_clr", bus.sat_flag, 0);

        // Clear coincident with a new saturating output: set wins
        drive(1'b1, 2'b00, -32768, 32767, -32768, -32768);
        step();
        drive(1'b0, 2'b00, 0, 0, 0, 0);
        step(); step();
        set_clr(1'b1); step();
        chk("coinc_valid", bus.out_valid, 1);
        chk("coinc_flag", bus.sat_flag, 1);
        step();
        set_clr(1'b0);
        chk("coinc_clr_after", bus.sat_flag, 0);

        // Table: back-to-back samples, each result three steps after its drive step
        for (int k = 0; k < 14; k++) begin
            if (k < 11) drive(1'b1, tbl[k].m, tbl[k].i, tbl[k].q, tbl[k].c, tbl[k].s);
            else        drive(1'b0, 2'b00, 0, 0, 0, 0);
            step();
            if (k >= 3) begin
                chk($sformatf("tbl%0d_valid", k - 3), bus.out_valid, 1);
                chk($sformatf("tbl%0d_y", k - 3), bus.y_out, tbl[k-3].y);
                chk($sformatf("tbl%0d_flag", k - 3), bus.sat_flag, int'(tbl[k-3].flag));
            end
        end
        drive(1'b0, 2'b00, 0, 0, 0, 0);
        step();
        chk("tbl_tail_valid", bus.out_valid, 0);
        set_clr(1'b1); step(); set_clr(1'b0);

        // Reset pulse in the middle of a 10-sample burst
        for (int n = 0; n < 10; n++) begin
            drive(1'b1, 2'($urandom_range(0, 3)), rnd_val(), rnd_val(), rnd_val(), rnd_val());
            reset = (n == 5);
            step();
            if (n == 5) chk("mid_rst_valid", bus.out_valid, 0);
            if (n >= 6 && n <= 8) chk("mid_rst_flushed", bus.out_valid, 0);
            if (n == 9) chk("mid_rst_first", bus.out_valid, 1);
        end
        reset = 1'b0;
        drive(1'b0, 2'b00, 0, 0, 0, 0);
        for (int n = 0; n < 4; n++) step();

        // Random streaming against the reference
        for (int n = 0; n < 10000; n++) begin
            drive(bit'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  rnd_val(), rnd_val(), rnd_val(), rnd_val());
            set_clr($urandom_range(0, 15) == 0);
            step();
        end
        drive(1'b0, 2'b00, 0, 0, 0, 0);
        set_clr(1'b0);
        for (int n = 0; n < 4; n++) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
